// File: rtl/dfifo32_pkg.sv
// Shared definitions for the DFIFO32 write and read controllers.
// Gray/binary helpers work at the widest legal pointer width; callers zero-extend and truncate.
package dfifo32_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned PTR_W_DEF      = ADDR_WIDTH_DEF + 1;
  localparam int unsigned PTR_W_MAX      = 11;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero, so a narrower pointer converts correctly after zero-extension.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = int'(PTR_W_MAX) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/dfifo32_wr_ctrl_if.sv
// Producer/RAM/pointer-exchange bundle for the DFIFO32 write controller.
interface dfifo32_wr_ctrl_if
  import dfifo32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic                  wr_req;
  logic [PTR_W-1:0]      rd_ptr_gray;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [PTR_W-1:0]      wr_ptr_gray;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic [PTR_W-1:0]      wr_water_level;
  logic                  wr_overflow;

  modport master (
    output wr_req, rd_ptr_gray,
    input  ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, wr_almost_full,
           wr_water_level, wr_overflow
  );

  modport slave (
    input  wr_req, rd_ptr_gray,
    output ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, wr_almost_full,
           wr_water_level, wr_overflow
  );

endinterface

// File: rtl/dfifo32_ptr_sync.sv
// Two-flop synchroniser for a Gray pointer crossing into the local clock domain.
module dfifo32_ptr_sync #(
  parameter int unsigned PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] ptr_o
);

  (* ASYNC_REG = "TRUE", dont_retime = "true" *) logic [PTR_W-1:0] s1_q;
  (* ASYNC_REG = "TRUE", dont_retime = "true" *) logic [PTR_W-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= ptr_i;
      s2_q <= s1_q;
    end
  end

  assign ptr_o = s2_q;

endmodule

// File: rtl/dfifo32_wr_ctrl.sv
// DFIFO32 write-side controller: write pointer, RAM write port, Gray export and
// full/almost-full/level status against the synchronised read pointer.
module dfifo32_wr_ctrl
  import dfifo32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_NUM = 28
) (
  input  logic             wr_clk,
  input  logic             asyn_rst,
  dfifo32_wr_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_bin_q,   wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q,  wr_gray_d;
  logic [PTR_W-1:0] level_q,    level_d;
  logic             full_q,     full_d;
  logic             afull_q,    afull_d;
  logic             ovf_q,      ovf_d;
  logic [PTR_W-1:0] rd_gray_s2;
  logic [PTR_W-1:0] rd_bin_s;
  logic [PTR_W-1:0] full_gray;
  logic             wr_en;

  dfifo32_ptr_sync #(
    .PTR_W (PTR_W)
  ) u_rd_sync (
    .clk   (wr_clk),
    .rst   (asyn_rst),
    .ptr_i (bus.rd_ptr_gray),
    .ptr_o (rd_gray_s2)
  );

  // Status is computed from the post-write pointer so it is valid one edge after the write.
  always_comb begin
    wr_en     = bus.wr_req & ~full_q;
    wr_bin_d  = wr_bin_q + PTR_W'(wr_en);
    wr_gray_d = PTR_W'(bin2gray(PTR_W_MAX'(wr_bin_d)));
    rd_bin_s  = PTR_W'(gray2bin(PTR_W_MAX'(rd_gray_s2)));
    full_gray = {~rd_gray_s2[PTR_W-1 -: 2], rd_gray_s2[PTR_W-3:0]};
    level_d   = wr_bin_d - rd_bin_s;
    full_d    = (wr_gray_d == full_gray);
    afull_d   = (level_d >= PTR_W'(ALMOST_FULL_NUM));
    ovf_d     = bus.wr_req & full_q;
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ram_wr_en      = wr_en;
  assign bus.ram_wr_addr    = wr_bin_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray    = wr_gray_q;
  assign bus.wr_full        = full_q;
  assign bus.wr_almost_full = afull_q;
  assign bus.wr_water_level = level_q;
  assign bus.wr_overflow    = ovf_q;

endmodule

// File: tb/tb_dfifo32_wr_ctrl.sv
// Self-checking bench for dfifo32_wr_ctrl: vector table for fill/overflow, directed
// sequences for reset, drain release, wrap-around and random traffic.
module tb_dfifo32_wr_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned AFN = 28;
  localparam int unsigned NV  = 36;

  typedef struct {
    logic          req;
    logic [PW-1:0] rdg;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic          exp_full;
    logic          exp_af;
    logic [PW-1:0] exp_lvl;
    logic          exp_ovf;
    logic [PW-1:0] exp_gray;
  } vec_t;

  logic wr_clk   = 1'b0;
  logic asyn_rst = 1'b1;

  dfifo32_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dfifo32_wr_ctrl #(
    .ADDR_WIDTH      (AW),
    .ALMOST_FULL_NUM (AFN)
  ) dut (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .bus      (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [PW-1:0] prev_gray = '0;
  vec_t          vecs[NV];

  function automatic logic [PW-1:0] g(input int unsigned n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called one time unit after a posedge; expected write addresses go to the scoreboard.
  task automatic drive(input logic req, input logic [PW-1:0] rdg,
                       input logic exp_en, input logic [AW-1:0] exp_addr);
    bus.wr_req      = req;
    bus.rd_ptr_gray = rdg;
    if (exp_en) exp_addr_q.push_back(exp_addr);
    #1;
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(exp_en));
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  // Write monitor and Gray single-bit-change check, sampled mid-cycle.
  always @(negedge wr_clk) begin
    if (asyn_rst) begin
      prev_gray = '0;
    end else begin
      if (bus.ram_wr_en) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.ram_wr_addr), 32'hFFFF_FFFF);
        end else begin
          chk("sb_ram_wr_addr", 32'(bus.ram_wr_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      chk("gray_hamming", 32'($countones(prev_gray ^ bus.wr_ptr_gray) <= 1), 1);
      prev_gray = bus.wr_ptr_gray;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    logic        r;

    for (int unsigned i = 0; i < 32; i++) begin
      vecs[i].req      = 1'b1;
      vecs[i].rdg      = '0;
      vecs[i].exp_en   = 1'b1;
      vecs[i].exp_addr = AW'(i);
      vecs[i].exp_full = (i + 1 == 32);
      vecs[i].exp_af   = (i + 1 >= AFN);
      vecs[i].exp_lvl  = PW'(i + 1);
      vecs[i].exp_ovf  = 1'b0;
      vecs[i].exp_gray = g(i + 1);
    end
    for (int unsigned i = 32; i < NV; i++) begin
      vecs[i].req      = (i < 35);
      vecs[i].rdg      = '0;
      vecs[i].exp_en   = 1'b0;
      vecs[i].exp_addr = '0;
      vecs[i].exp_full = 1'b1;
      vecs[i].exp_af   = 1'b1;
      vecs[i].exp_lvl  = PW'(32);
      vecs[i].exp_ovf  = (i < 35);
      vecs[i].exp_gray = g(32);
    end

    // Power-on reset values
    bus.wr_req      = 1'b0;
    bus.rd_ptr_gray = '0;
    #1;
    chk("rst_en",    32'(bus.ram_wr_en), 0);
    chk("rst_addr",  32'(bus.ram_wr_addr), 0);
    chk("rst_gray",  32'(bus.wr_ptr_gray), 0);
    chk("rst_full",  32'(bus.wr_full), 0);
    chk("rst_af",    32'(bus.wr_almost_full), 0);
    chk("rst_lvl",   32'(bus.wr_water_level), 0);
    chk("rst_ovf",   32'(bus.wr_overflow), 0);
    bus.wr_req = 1'b1;
    #1;
    chk("rst_en_follows_req", 32'(bus.ram_wr_en), 1);
    bus.wr_req = 1'b0;
    @(posedge wr_clk);
    #3 asyn_rst = 1'b0;
    step();

    // Reset during traffic
    for (int unsigned i = 0; i < 10; i++) begin
      drive(1'b1, '0, 1'b1, AW'(i));
      step();
      chk("pre_rst_gray", 32'(bus.wr_ptr_gray), 32'(g(i + 1)));
    end
    chk("pre_rst_lvl", 32'(bus.wr_water_level), 10);
    bus.wr_req = 1'b0;
    #2 asyn_rst = 1'b1;
    #1;
    chk("midrst_en",   32'(bus.ram_wr_en), 0);
    chk("midrst_addr", 32'(bus.ram_wr_addr), 0);
    chk("midrst_gray", 32'(bus.wr_ptr_gray), 0);
    chk("midrst_full", 32'(bus.wr_full), 0);
    chk("midrst_af",   32'(bus.wr_almost_full), 0);
    chk("midrst_lvl",  32'(bus.wr_water_level), 0);
    chk("midrst_ovf",  32'(bus.wr_overflow), 0);
    @(posedge wr_clk);
    #3 asyn_rst = 1'b0;
    step();
    chk("post_rst_addr", 32'(bus.ram_wr_addr), 0);

    // Fill from empty, then push while full
    for (int unsigned i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].rdg, vecs[i].exp_en, vecs[i].exp_addr);
      chk("tbl_addr", 32'(bus.ram_wr_addr), 32'(vecs[i].exp_addr));
      step();
      chk("tbl_full", 32'(bus.wr_full), 32'(vecs[i].exp_full));
      chk("tbl_af",   32'(bus.wr_almost_full), 32'(vecs[i].exp_af));
      chk("tbl_lvl",  32'(bus.wr_water_level), 32'(vecs[i].exp_lvl));
      chk("tbl_ovf",  32'(bus.wr_overflow), 32'(vecs[i].exp_ovf));
      chk("tbl_gray", 32'(bus.wr_ptr_gray), 32'(vecs[i].exp_gray));
    end

    // Drain release: read pointer moves to 4
    drive(1'b0, 6'b000110, 1'b0, '0);
    for (int unsigned e = 1; e <= 3; e++) begin
      step();
      chk("drain_full", 32'(bus.wr_full), 32'(e < 3));
    end
    chk("drain_lvl", 32'(bus.wr_water_level), 28);
    chk("drain_af",  32'(bus.wr_almost_full), 1);

    bus.rd_ptr_gray = '0;
    #2 asyn_rst = 1'b1;
    @(posedge wr_clk);
    #3 asyn_rst = 1'b0;
    step();

    // Wrap-around with the read pointer tracking the writes
    for (int unsigned j = 1; j <= 40; j++) begin
      drive(1'b1, g(j - 1), 1'b1, AW'(j - 1));
      step();
      chk("wrap_gray", 32'(bus.wr_ptr_gray), 32'(g(j)));
      chk("wrap_full", 32'(bus.wr_full), 0);
      chk("wrap_lvl",  32'(bus.wr_water_level), (j < 3) ? j : 3);
      if (j == 31) chk("wrap_msb_before", 32'(bus.wr_ptr_gray[PW-1]), 0);
      if (j == 32) chk("wrap_msb_after",  32'(bus.wr_ptr_gray[PW-1]), 1);
    end

    // Random requests, FIFO kept from filling
    n = 40;
    for (int unsigned c = 0; c < 1000; c++) begin
      r = 1'($urandom_range(0, 1));
      drive(r, g(n), r, AW'(n));
      step();
      if (r) n++;
      chk("rand_gray", 32'(bus.wr_ptr_gray), 32'(g(n)));
    end

    bus.wr_req = 1'b0;
    step();
    chk("sb_empty", 32'(exp_addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
